// File: rtl/serial_adder_if.sv
// Bit-serial operand/result bundle for serial_adder.
// Signal semantics: there is no valid/ready pair. Every rising clk edge
// outside reset consumes one (a,b) pair, and sum/carry always present the
// registered result of the most recently consumed pair.
interface serial_adder_if;
  logic a;
  logic b;
  logic sum;
  logic carry;

  // Source of operand bits, sink of results.
  modport master (
    output a,
    output b,
    input  sum,
    input  carry
  );

  // The adder itself.
  modport slave (
    input  a,
    input  b,
    output sum,
    output carry
  );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder, LSB first, one bit pair per clock.
// The carry is held in a two-state FSM (C0/C1) whose state is also the
// carry output. With WORD_LEN > 0 a bit counter frames words: the first
// pair of each word adds with cin = 0, while the carry output still shows
// the true carry-out of the last bit of the previous word for one cycle.
// The ports are plain scalars in a fixed order so positional instantiation
// keeps working; serial_adder_if bundles the same four data signals for
// the surrounding environment.
module serial_adder #(
  parameter int WORD_LEN = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry
);

  localparam int CNT_W = (WORD_LEN > 1) ? $clog2(WORD_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'((WORD_LEN > 0) ? WORD_LEN - 1 : 0);

  typedef enum logic {
    C0 = 1'b0,
    C1 = 1'b1
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic             sum_q;
  logic             sum_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             cin;
  logic [1:0]       total;

  // State, sum and bit counter registers; reset clears everything at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= C0;
      sum_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
    end
  end

  // Full-add the sampled pair with the carry-in and advance the word counter.
  always_comb begin
    cin     = (state_q == C1);
    total   = 2'b00;
    sum_d   = sum_q;
    state_d = state_q;
    cnt_d   = cnt_q;

    // Counter at 0 means this pair opens a new word: the previous carry
    // is shown on the output but must not feed into this word.
    if ((WORD_LEN > 0) && (cnt_q == '0)) begin
      cin = 1'b0;
    end

    total   = {1'b0, a} + {1'b0, b} + {1'b0, cin};
    sum_d   = total[0];
    state_d = total[1] ? C1 : C0;

    if (WORD_LEN > 0) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  assign sum   = sum_q;
  assign carry = (state_q == C1);

endmodule

// File: tb/tb_serial_adder.sv
// Testbench for serial_adder: an unbounded instance (WORD_LEN=0) and a
// framed instance (WORD_LEN=4) share clk/rst and take independent bit
// streams. Expected results come from arithmetic reference models and
// flow through per-instance expected queues.
module tb_serial_adder;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  serial_adder_if if0 ();
  serial_adder_if if4 ();

  serial_adder #(.WORD_LEN(0)) dut0 (
    .clk   (clk),
    .rst   (rst),
    .a     (if0.a),
    .b     (if0.b),
    .sum   (if0.sum),
    .carry (if0.carry)
  );

  serial_adder #(.WORD_LEN(4)) dut4 (
    .clk   (clk),
    .rst   (rst),
    .a     (if4.a),
    .b     (if4.b),
    .sum   (if4.sum),
    .carry (if4.carry)
  );

  // ---------------- scoreboard state ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [1:0] exp_q0[$];   // {sum, carry} for dut0
  logic [1:0] exp_q4[$];   // {sum, carry} for dut4

  // Unbounded model: plain integer carry chain.
  int m0_cin = 0;

  // Framed model: operand words built up bit by bit, the sum bit and
  // carry are read straight from the integer sum of the partial words.
  int m4_wa  = 0;
  int m4_wb  = 0;
  int m4_idx = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] model0(input logic a, input logic b);
    int t;
    t = int'(a) + int'(b) + m0_cin;
    m0_cin = t / 2;
    return {1'(t % 2), 1'(t / 2)};
  endfunction

  function automatic logic [1:0] model4(input logic a, input logic b);
    int s;
    logic [1:0] r;
    m4_wa = m4_wa + (int'(a) << m4_idx);
    m4_wb = m4_wb + (int'(b) << m4_idx);
    s = m4_wa + m4_wb;
    r = {1'((s >> m4_idx) & 1), 1'((s >> (m4_idx + 1)) & 1)};
    m4_idx = m4_idx + 1;
    if (m4_idx == 4) begin
      m4_idx = 0;
      m4_wa  = 0;
      m4_wb  = 0;
    end
    return r;
  endfunction

  function automatic void model_reset();
    m0_cin = 0;
    m4_wa  = 0;
    m4_wb  = 0;
    m4_idx = 0;
  endfunction

  // ---------------- driver tasks ----------------
  // Both tasks are entered and left at a falling clk edge so that every
  // rising edge outside reset is accounted for by the models.
  task automatic step(input logic a0, input logic b0, input logic a4, input logic b4,
                      input string tag);
    logic [1:0] e;
    logic [1:0] got;
    if0.a = a0;
    if0.b = b0;
    if4.a = a4;
    if4.b = b4;
    exp_q0.push_back(model0(a0, b0));
    exp_q4.push_back(model4(a4, b4));
    @(posedge clk);
    #1;
    e   = exp_q0.pop_front();
    got = {if0.sum, if0.carry};
    check({tag, "/w0"}, 32'(got), 32'(e));
    e   = exp_q4.pop_front();
    got = {if4.sum, if4.carry};
    check({tag, "/w4"}, 32'(got), 32'(e));
    @(negedge clk);
  endtask

  // Assert reset between edges, confirm outputs clear without a clock,
  // hold across one rising edge and release at the next falling edge.
  task automatic pulse_reset(input string tag);
    rst = 1'b1;
    #1;
    check({tag, "/async_w0"}, 32'({if0.sum, if0.carry}), 32'(0));
    check({tag, "/async_w4"}, 32'({if4.sum, if4.carry}), 32'(0));
    model_reset();
    @(posedge clk);
    #1;
    check({tag, "/hold_w0"}, 32'({if0.sum, if0.carry}), 32'(0));
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "timeout");
  end

  // ---------------- main sequence ----------------
  logic [1:0] pairs [8] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00, 2'b01, 2'b10, 2'b11};
  logic [1:0] chain [8] = '{2'b00, 2'b10, 2'b10, 2'b01, 2'b10, 2'b10, 2'b10, 2'b01};
  logic [3:0] w1a = 4'b1111;
  logic [3:0] w1b = 4'b0001;
  logic [3:0] w2a = 4'b0001;
  logic [3:0] w2b = 4'b0000;

  initial begin
    // Reset held 20 ns with a=b=0.
    if0.a = 1'b0; if0.b = 1'b0;
    if4.a = 1'b0; if4.b = 1'b0;
    rst = 1'b1;
    #2;
    check("reset_t2_w0", 32'({if0.sum, if0.carry}), 32'(0));
    check("reset_t2_w4", 32'({if4.sum, if4.carry}), 32'(0));
    @(posedge clk); #1;
    check("reset_edge_w0", 32'({if0.sum, if0.carry}), 32'(0));
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    model_reset();
    step(1'b0, 1'b0, 1'b0, 1'b0, "first_add");

    // Unbounded chain through all four pair combinations, twice.
    for (int i = 0; i < 8; i++) begin
      step(pairs[i][1], pairs[i][0], 1'b0, 1'b0, $sformatf("chain%0d", i));
      check($sformatf("chain%0d_table", i), 32'({if0.sum, if0.carry}), 32'(chain[i]));
    end

    // Sustained carry.
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, 1'b1, 1'b1, $sformatf("sustain%0d", i));
      check($sformatf("sustain%0d_table", i), 32'({if0.sum, if0.carry}), 32'(2'b11));
    end

    // Asynchronous reset while carry=1, then the next add must use cin=0.
    pulse_reset("mid_reset");
    step(1'b1, 1'b0, 1'b1, 1'b0, "post_reset");
    check("post_reset_table", 32'({if0.sum, if0.carry}), 32'(2'b10));

    // Word framing: 1111+0001 then 0001+0000 on the framed instance.
    pulse_reset("frame_reset");
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, w1a[i], w1b[i], $sformatf("word1_b%0d", i));
      check($sformatf("word1_b%0d_table", i), 32'({if4.sum, if4.carry}), 32'(2'b01));
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, w2a[i], w2b[i], $sformatf("word2_b%0d", i));
      if (i == 0)
        check("word2_b0_table", 32'({if4.sum, if4.carry}), 32'(2'b10));
    end

    // Random stream with occasional reset pulses.
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 24) == 0) begin
        pulse_reset($sformatf("rnd_reset%0d", i));
      end
      step(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
           $sformatf("rnd%0d", i));
    end

    check("queue_empty_w0", 32'(exp_q0.size()), 32'(0));
    check("queue_empty_w4", 32'(exp_q4.size()), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The block SHALL provide parameter WORD_LEN, default 0, giving the number of bit-times per word; 0 means unbounded, with carry never auto-cleared.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port a, input, 1 bit: operand A serial bit, LSB first.
REQ-005 The block SHALL have port b, input, 1 bit: operand B serial bit, LSB first.
REQ-006 The block SHALL have port sum, output, 1 bit: registered sum bit of the most recently added bit pair.
REQ-007 The block SHALL have port carry, output, 1 bit: registered carry-out of the most recently added bit pair; this is also the carry-in for the next pair.
REQ-008 Port order SHALL be clk, rst, a, b, sum, carry, so that positional instantiation works.

Function
REQ-009 The carry state SHALL be a two-state FSM: C0 (carry 0) and C1 (carry 1).
REQ-010 At each rising clk edge with rst low, the block SHALL sample a and b and compute t = a + b + cin, where cin is the current carry state.
- sum SHALL be loaded with t[0].
- carry and the FSM state SHALL be loaded with t[1].
REQ-011 The FSM transitions SHALL be:
- C0 to C1 only when a=b=1.
- C1 to C0 only when a=b=0.
- Otherwise the state is held.
REQ-012 Latency SHALL be one clock: a bit pair sampled at edge n appears on sum/carry after edge n and holds until edge n+1.
REQ-013 Outputs SHALL be driven only from registers, with no combinational path from a/b to sum/carry.
REQ-014 When WORD_LEN > 0, an internal bit counter SHALL count sampled pairs from 0 to WORD_LEN-1.
- On the edge that samples pair WORD_LEN-1, sum and carry SHALL load normally.
- The counter SHALL wrap to 0.
- The next pair SHALL use cin = 0, not the carry output.
REQ-015 When WORD_LEN > 0, the carry output SHALL still show the true carry-out of the final bit of a word for one cycle.
REQ-016 When WORD_LEN = 0, the counter SHALL be unused and the carry SHALL chain indefinitely.
REQ-017 There SHALL be no enable or handshake: every clock edge out of reset consumes one bit pair.
REQ-018 The counter width SHALL be clog2(WORD_LEN) bits, with a minimum of 1, and SHALL wrap without overflow at WORD_LEN-1.

Reset
REQ-019 While rst is high, the block SHALL force sum=0, carry=0, FSM=C0 and counter=0 immediately, without waiting for a clock edge.
REQ-020 Reset asserted mid-word SHALL discard the partial word; the first edge after release SHALL treat its pair as bit 0 with cin=0.
REQ-021 On release of rst, the first rising edge with rst low SHALL perform a normal add.

Verification
REQ-022 Reset check: hold rst=1 for 20 ns (clk period 10 ns, a=b=0), then release -> sum=0, carry=0 throughout reset; sum=0, carry=0 after the first edge.
REQ-023 Unbounded chain (WORD_LEN=0): apply pairs (a,b) = 00, 01, 10, 11, 00, 01, 10, 11, one per clock -> (sum,carry) after each edge = 00, 10, 10, 01, 10, 10, 10, 01.
REQ-024 Sustained carry: continue a=b=1 after REQ-023 -> sum=1, carry=1 on every subsequent edge.
REQ-025 Asynchronous reset: assert rst between edges while carry=1 -> sum and carry go to 0 before the next edge; the next add after release uses cin=0.
REQ-026 Word framing (WORD_LEN=4): add 4'b1111 + 4'b0001 LSB first, then a second word 0001 + 0000 -> word 1 sum bits 0,0,0,0 with carry=1 after bit 3; word 2 bit 0 gives sum=1, carry=0, so no carry leaks across the word boundary.
REQ-027 Random check: compare a 200-cycle random stream against a reference model of a+b+cin, with reset pulses inserted -> zero mismatches.
